// File: rtl/if_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : if_prefetch
// Brief    : Instruction-fetch stage: PC register, synchronous-read imem and a
//            credit-controlled prefetch queue with a valid/ready head port.
// Revision : 1.0
// ============================================================================
module if_prefetch #(
    parameter int               WIDTH      = 32,
    parameter int               IMEM_DEPTH = 256,
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int               FIFO_DEPTH = 2,
    parameter                   INIT_FILE  = ""
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] PC_JMP,
    input  logic             branch,
    input  logic             ALU_zero,
    input  logic             instr_ready,
    output logic             instr_valid,
    output logic [31:0]      instruction,
    output logic [WIDTH-1:0] PC,
    output logic             fetch_fault
);

    localparam int                 c_IDX_W       = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int                 c_PTR_W       = $clog2(FIFO_DEPTH);
    localparam int                 c_CNT_W       = $clog2(FIFO_DEPTH + 1) + 1;
    localparam logic [31:0]        c_NOP         = 32'h0000_0013;
    localparam logic [WIDTH-1:0]   c_DEPTH_WORDS = WIDTH'(IMEM_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST    = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [c_CNT_W:0]   c_CREDIT_MAX  = (c_CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_COUNT_MAX   = c_CNT_W'(FIFO_DEPTH);

    logic [31:0]        r_mem [IMEM_DEPTH];

    logic [WIDTH-1:0]   r_fetch_pc;
    logic               r_rd_valid;
    logic [WIDTH-1:0]   r_rd_pc;
    logic               r_rd_fault;
    logic [31:0]        r_rd_data;

    logic [31:0]        r_q_instr [FIFO_DEPTH];
    logic [WIDTH-1:0]   r_q_pc    [FIFO_DEPTH];
    logic               r_q_fault [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;

    logic               w_redirect;
    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic               w_fault;
    logic [WIDTH-1:0]   w_word;
    logic [c_IDX_W-1:0] w_idx;
    logic [c_CNT_W:0]   w_credit;
    logic [31:0]        w_push_instr;

    function automatic logic [c_PTR_W-1:0] f_ptr_next(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_redirect   = branch & ALU_zero;
    assign w_pop        = instr_valid & instr_ready & ~w_redirect;
    assign w_push       = r_rd_valid & ~w_redirect;
    assign w_word       = {2'b00, r_fetch_pc[WIDTH-1:2]};
    assign w_idx        = r_fetch_pc[c_IDX_W+1:2];
    assign w_fault      = (r_fetch_pc[1:0] != 2'b00) || (w_word >= c_DEPTH_WORDS);
    assign w_push_instr = r_rd_fault ? c_NOP : r_rd_data;

    // Entries already owned (queued + in flight) minus the one leaving now.
    assign w_credit = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_rd_valid}
                    - {{c_CNT_W{1'b0}}, w_pop};
    assign w_issue  = ~w_redirect && (w_credit < c_CREDIT_MAX);

    always_ff @(posedge clk) begin
        r_rd_data <= r_mem[w_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_rd_valid <= 1'b0;
            r_rd_pc    <= '0;
            r_rd_fault <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else if (w_redirect) begin
            r_fetch_pc <= PC_JMP;
            r_rd_valid <= 1'b0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_rd_valid <= w_issue;
            if (w_issue) begin
                r_fetch_pc <= r_fetch_pc + WIDTH'(4);
                r_rd_pc    <= r_fetch_pc;
                r_rd_fault <= w_fault;
            end
            if (w_push) r_wptr <= f_ptr_next(r_wptr);
            if (w_pop)  r_rptr <= f_ptr_next(r_rptr);
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_push) begin
            r_q_instr[r_wptr] <= w_push_instr;
            r_q_pc[r_wptr]    <= r_rd_pc;
            r_q_fault[r_wptr] <= r_rd_fault;
        end
    end

    assign instr_valid = (r_count != '0);
    assign instruction = instr_valid ? r_q_instr[r_rptr] : 32'h0;
    assign PC          = instr_valid ? r_q_pc[r_rptr]    : '0;
    assign fetch_fault = instr_valid ? r_q_fault[r_rptr] : 1'b0;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= c_COUNT_MAX);

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && !w_pop && r_count == c_COUNT_MAX));

endmodule
`default_nettype wire

// File: tb/tb_if_prefetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_prefetch
// Brief    : Directed scenarios plus randomized ready/redirect traffic checked
//            against an in-order fetch-stream model.
// Revision : 1.0
// ============================================================================
module tb_if_prefetch;

    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_jmp;
    logic        branch;
    logic        alu_zero;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        fetch_fault;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    if_prefetch #(
        .WIDTH      (32),
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (2),
        .INIT_FILE  ("")
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PC_JMP      (pc_jmp),
        .branch      (branch),
        .ALU_zero    (alu_zero),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instruction (instruction),
        .PC          (pc),
        .fetch_fault (fetch_fault)
    );

    function automatic logic exp_fault(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        logic [31:0] w = a >> 2;
        if (exp_fault(a)) return 32'h0000_0013;
        return model_mem[w[7:0]];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in cycle 0 after reset release.
    task automatic do_reset();
        rst_n = 1'b0; branch = 1'b0; alu_zero = 1'b0; pc_jmp = '0; instr_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    // Redirect in the current cycle T; returns at the start of T+1.
    task automatic apply_redirect(input logic [31:0] tgt);
        pc_jmp = tgt; branch = 1'b1; alu_zero = 1'b1;
        tick();
        branch = 1'b0; alu_zero = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; branch = 1'b0; alu_zero = 1'b0; pc_jmp = '0; instr_ready = 1'b1;
        tick(); tick();
        checks++;
        if ({instr_valid, pc, instruction, fetch_fault} !== 66'b0) begin
            failures++;
            $display("FAIL reset_state: got v=%b pc=%h ins=%h f=%b, want all zero", instr_valid, pc, instruction, fetch_fault);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_latency: cycle %0d got v=%b want 0", c, instr_valid);
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({instr_valid, pc, instruction, fetch_fault} !== {1'b1, 32'(4 * k), model_mem[k], 1'b0}) begin
                failures++;
                $display("FAIL reset_stream: k=%0d got v=%b pc=%h ins=%h f=%b want pc=%h ins=%h", k, instr_valid, pc, instruction, fetch_fault, 32'(4 * k), model_mem[k]);
            end
            tick();
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        repeat (4) tick();
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({instr_valid, pc, instruction} !== {1'b1, 32'h8, model_mem[2]}) begin
                failures++;
                $display("FAIL bp_hold: i=%0d got v=%b pc=%h ins=%h want pc=00000008 ins=%h", i, instr_valid, pc, instruction, model_mem[2]);
            end
            tick();
        end
        instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if ({instr_valid, pc, instruction} !== {1'b1, 32'(8 + 4 * k), exp_instr(32'(8 + 4 * k))}) begin
                failures++;
                $display("FAIL bp_resume: k=%0d got v=%b pc=%h want pc=%h", k, instr_valid, pc, 32'(8 + 4 * k));
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (5) tick();
        apply_redirect(32'h40);
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL redir_flush: T+%0d got v=%b pc=%h want v=0", c, instr_valid, pc);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({instr_valid, pc, instruction, fetch_fault} !== {1'b1, 32'(64 + 4 * k), model_mem[16 + k], 1'b0}) begin
                failures++;
                $display("FAIL redir_target: k=%0d got v=%b pc=%h ins=%h want pc=%h", k, instr_valid, pc, instruction, 32'(64 + 4 * k));
            end
            tick();
        end
        pc_jmp = 32'h200; branch = 1'b1; alu_zero = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({instr_valid, pc} !== {1'b1, 32'(72 + 4 * k)}) begin
                failures++;
                $display("FAIL redir_nottaken: k=%0d got v=%b pc=%h want pc=%h", k, instr_valid, pc, 32'(72 + 4 * k));
            end
            tick();
        end
        branch = 1'b0;
    endtask

    task automatic test_redirect_full();
        do_reset();
        repeat (3) tick();
        instr_ready = 1'b0;
        repeat (4) tick();
        checks++;
        if ({instr_valid, pc} !== {1'b1, 32'h4}) begin
            failures++;
            $display("FAIL full_hold: got v=%b pc=%h want pc=00000004", instr_valid, pc);
        end
        apply_redirect(32'h100);
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL full_flush: T+%0d got v=%b pc=%h want v=0", c, instr_valid, pc);
            end
            tick();
        end
        checks++;
        if ({instr_valid, pc, instruction} !== {1'b1, 32'h100, model_mem[64]}) begin
            failures++;
            $display("FAIL full_target: got v=%b pc=%h ins=%h want pc=00000100 ins=%h", instr_valid, pc, instruction, model_mem[64]);
        end
        instr_ready = 1'b1;
        tick();
        checks++;
        if ({instr_valid, pc} !== {1'b1, 32'h104}) begin
            failures++;
            $display("FAIL full_next: got v=%b pc=%h want pc=00000104", instr_valid, pc);
        end
    endtask

    task automatic test_fault();
        logic [31:0] tgts [5];
        tgts = '{32'h42, 32'(4 * DEPTH), 32'h0, 32'hFFFF_FFFC, 32'h3FC};
        do_reset();
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            apply_redirect(tgts[i]);
            tick(); tick();
            for (int k = 0; k < 2; k++) begin
                logic [31:0] a;
                a = tgts[i] + 32'(4 * k);
                checks++;
                if ({instr_valid, pc, instruction, fetch_fault} !== {1'b1, a, exp_instr(a), exp_fault(a)}) begin
                    failures++;
                    $display("FAIL fault_entry: pc want %h got v=%b pc=%h ins=%h f=%b want ins=%h f=%b", a, instr_valid, pc, instruction, fetch_fault, exp_instr(a), exp_fault(a));
                end
                tick();
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (5) tick();
        rst_n = 1'b0; branch = 1'b1; alu_zero = 1'b1; pc_jmp = 32'h80;
        tick();
        rst_n = 1'b1; branch = 1'b0; alu_zero = 1'b0;
        for (int c = 0; c < 2; c++) begin
            checks++;
            if ({instr_valid, pc, instruction, fetch_fault} !== 66'b0) begin
                failures++;
                $display("FAIL midreset_blank: cycle %0d got v=%b pc=%h want v=0", c, instr_valid, pc);
            end
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({instr_valid, pc, instruction} !== {1'b1, 32'(4 * k), model_mem[k]}) begin
                failures++;
                $display("FAIL midreset_restart: k=%0d got v=%b pc=%h want pc=%h", k, instr_valid, pc, 32'(4 * k));
            end
            tick();
        end
    endtask

    // Model: the delivered stream is start, start+4, ... restarted by every
    // taken redirect; the head appears 3 cycles after a redirect (2 after
    // reset release) and, with two queue entries, never drops out afterwards.
    task automatic test_random();
        logic [31:0] exp_pc;
        int          blank;
        bit          armed;
        bit          redir;
        do_reset();
        exp_pc = 32'h0; blank = 2; armed = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (blank > 0) begin
                checks++;
                if (instr_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL rnd_blank: cyc %0d got v=%b pc=%h want v=0", cyc, instr_valid, pc);
                end
                blank--;
                if (blank == 0) armed = 1'b1;
            end else if (armed) begin
                checks++;
                if (instr_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL rnd_bubble: cyc %0d got v=%b want v=1", cyc, instr_valid);
                end
            end
            checks++;
            if (instr_valid === 1'b1) begin
                if ({pc, instruction, fetch_fault} !== {exp_pc, exp_instr(exp_pc), exp_fault(exp_pc)}) begin
                    failures++;
                    $display("FAIL rnd_head: cyc %0d got pc=%h ins=%h f=%b want pc=%h ins=%h f=%b", cyc, pc, instruction, fetch_fault, exp_pc, exp_instr(exp_pc), exp_fault(exp_pc));
                end
            end else if ({instr_valid, pc, instruction, fetch_fault} !== 66'b0) begin
                failures++;
                $display("FAIL rnd_idle: cyc %0d got v=%b pc=%h ins=%h f=%b want zeros", cyc, instr_valid, pc, instruction, fetch_fault);
            end

            instr_ready = ($urandom_range(0, 3) != 0);
            redir       = ($urandom_range(0, 15) == 0);
            branch      = redir || ($urandom_range(0, 7) == 0);
            alu_zero    = redir;
            case ($urandom_range(0, 7))
                5:       pc_jmp = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
                6:       pc_jmp = 32'h400 + 32'(4 * $urandom_range(0, 15));
                7:       pc_jmp = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
                default: pc_jmp = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            endcase
            if (redir) begin
                exp_pc = pc_jmp; blank = 2; armed = 1'b0;
            end else if (instr_valid && instr_ready) begin
                exp_pc = exp_pc + 32'h4;
            end
            tick();
        end
        branch = 1'b0; alu_zero = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; branch = 1'b0; alu_zero = 1'b0; pc_jmp = '0; instr_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = $urandom();
            dut.r_mem[i] = model_mem[i];
        end
        test_reset();
        test_back_pressure();
        test_redirect();
        test_redirect_full();
        test_fault();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
